// File: rtl/count_display_driver.sv
// Binary-to-BCD shift-add-3 converter feeding a scanned common-anode 7-segment display.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks zero digits above the highest nonzero digit.
module count_display_driver #(
  parameter int WIDTH    = 4,
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                bcd_valid,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]     CNT_LAST   = CW'(WIDTH - 1);
  localparam logic [PW-1:0]     PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_RESET   = ~DIGITS'(1);
  localparam logic [6:0]        SEG_ZERO   = 7'b1000000;
  localparam logic [6:0]        SEG_BLANK  = 7'b1111111;

  typedef enum logic {IDLE, CONV} state_t;
  state_t state, next_state;

  logic [WIDTH-1:0]    shreg, shreg_sh;
  logic [4*DIGITS-1:0] acc, acc_adj, acc_sh;
  logic [CW-1:0]       cnt;
  logic                accept, done;

  logic [PW-1:0] presc;
  logic [IW-1:0] idx, idx_next;
  logic          wrap;
  logic [3:0]    nib;
  logic          blank;

  function automatic logic [6:0] decode7(input logic [3:0] d);
    case (d)
      4'd0:    decode7 = 7'b1000000;
      4'd1:    decode7 = 7'b1111001;
      4'd2:    decode7 = 7'b0100100;
      4'd3:    decode7 = 7'b0110000;
      4'd4:    decode7 = 7'b0011001;
      4'd5:    decode7 = 7'b0010010;
      4'd6:    decode7 = 7'b0000010;
      4'd7:    decode7 = 7'b1111000;
      4'd8:    decode7 = 7'b0000000;
      4'd9:    decode7 = 7'b0010000;
      default: decode7 = SEG_BLANK;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = CONV;
      CONV:    if (done)   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    accept = (state == IDLE) && din_valid;
    done   = (state == CONV) && (cnt == CNT_LAST);
  end

  // One shift-add-3 step: correct every nibble >=5, then shift {acc,shreg} left by one.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    {acc_sh, shreg_sh} = {acc_adj, shreg} << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      acc       <= '0;
      cnt       <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      din_ready <= 1'b1;
    end else begin
      bcd_valid <= done;
      din_ready <= (next_state == IDLE);
      if (accept) begin
        shreg <= din;
        acc   <= '0;
        cnt   <= '0;
      end else if (state == CONV) begin
        shreg <= shreg_sh;
        acc   <= acc_sh;
        cnt   <= cnt + 1'b1;
        if (done) bcd_out <= acc_sh;
      end
    end
  end

  always_comb begin
    wrap     = (presc == PRESC_LAST);
    idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] lead;
`endif

  // Selects the digit that becomes active on the next scan step; lead tracks the top nonzero digit.
  always_comb begin
    nib = '0;
`ifdef LEADING_ZERO_BLANK_EN
    lead = '0;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_next == IW'(i)) nib = bcd_out[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      if (bcd_out[4*i +: 4] != 4'd0) lead = IW'(i);
`endif
    end
`ifdef LEADING_ZERO_BLANK_EN
    blank = (idx_next > lead);
`else
    blank = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
      an    <= AN_RESET;
      seg   <= SEG_ZERO;
    end else if (wrap) begin
      presc <= '0;
      idx   <= idx_next;
      an    <= ~(DIGITS'(1) << idx_next);
      seg   <= blank ? SEG_BLANK : decode7(nib);
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// Scoreboard bench for count_display_driver (WIDTH=4, DIGITS=2, SCAN_DIV=4).
`timescale 1ns/1ps
module tb_count_display_driver;

  localparam int WIDTH    = 4;
  localparam int DIGITS   = 2;
  localparam int SCAN_DIV = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [WIDTH-1:0]    din = '0;
  logic                din_valid = 1'b0;
  logic                din_ready;
  logic [4*DIGITS-1:0] bcd_out;
  logic                bcd_valid;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;

  count_display_driver #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .bcd_out(bcd_out), .bcd_valid(bcd_valid), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] bcd; int cyc; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] SEG_D1_OF_7 = 7'b1111111;
`else
  localparam logic [6:0] SEG_D1_OF_7 = 7'b1000000;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every bcd_valid pulse must match the oldest expected result, value and cycle.
  always @(negedge clk) begin
    if (bcd_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_bcd_valid: got bcd_out=%0h, expected no result (cycle %0d)", bcd_out, cyc);
      end else begin
        mon_e = sbq.pop_front();
        checkOutput("bcd_out", 32'(bcd_out), 32'(mon_e.bcd));
        checkOutput("bcd_latency_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic waitReady();
    for (int n = 0; n < 20 && din_ready !== 1'b1; n++) @(negedge clk);
    checkOutput("din_ready_before_accept", 32'(din_ready), 32'd1);
  endtask

  task automatic applyStimulus(input logic [3:0] value, input logic [7:0] expBcd);
    waitReady();
    din       = value;
    din_valid = 1'b1;
    sbq.push_back('{expBcd, cyc + 1 + WIDTH});
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic checkReset();
    checkOutput("reset_din_ready", 32'(din_ready), 32'd1);
    checkOutput("reset_bcd_valid", 32'(bcd_valid), 32'd0);
    checkOutput("reset_bcd_out", 32'(bcd_out), 32'h00);
    checkOutput("reset_an", 32'(an), 32'b10);
    checkOutput("reset_seg", 32'(seg), 32'b1000000);
  endtask

  task automatic checkScan(input string tag, input logic [6:0] seg0, input logic [6:0] seg1);
    logic [1:0] prev, an0, expAn;
    bit found = 0;
    prev = an;
    for (int i = 0; i < 2*SCAN_DIV + 2 && !found; i++) begin
      @(negedge clk);
      if (an !== prev) found = 1;
    end
    checkOutput({tag, "_scan_step_seen"}, 32'(found), 32'd1);
    an0 = an;
    checkOutput({tag, "_an_onehot"}, 32'(an0 == 2'b10 || an0 == 2'b01), 32'd1);
    for (int k = 0; k < 3*SCAN_DIV; k++) begin
      expAn = (((k / SCAN_DIV) % 2) == 0) ? an0 : ~an0;
      checkOutput({tag, "_an"}, 32'(an), 32'(expAn));
      checkOutput({tag, "_seg"}, 32'(seg), 32'((expAn == 2'b10) ? seg0 : seg1));
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkReset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // din=9: busy for exactly WIDTH cycles; a busy-time din_valid is ignored
    applyStimulus(4'd9, 8'h09);
    for (int k = 0; k < WIDTH; k++) begin
      checkOutput("din_ready_busy", 32'(din_ready), 32'd0);
      if (k == 1) begin din = 4'd14; din_valid = 1'b1; end
      if (k == 2) din_valid = 1'b0;
      @(negedge clk);
    end
    checkOutput("din_ready_after_conv", 32'(din_ready), 32'd1);
    repeat (2) @(negedge clk);

    applyStimulus(4'd15, 8'h15);
    repeat (10) @(negedge clk);
    checkScan("d15", 7'b0010010, 7'b1111001);

    // din_valid held high across two conversions; busy-time din changes must not be captured
    waitReady();
    din       = 4'd3;
    din_valid = 1'b1;
    sbq.push_back('{8'h03, cyc + 1 + WIDTH});
    sbq.push_back('{8'h07, cyc + 2 + 2*WIDTH});
    @(negedge clk); din = 4'd9;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); din = 4'd7;
    @(negedge clk);
    @(negedge clk); din_valid = 1'b0; din = 4'd5;
    checkOutput("din_ready_second_accept", 32'(din_ready), 32'd0);
    repeat (8) @(negedge clk);

    // Reset during the second CONV cycle of din=12 discards the conversion
    waitReady();
    din       = 4'd12;
    din_valid = 1'b1;
    @(negedge clk); din_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    checkReset();
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("bcd_out_after_reset", 32'(bcd_out), 32'h00);

    applyStimulus(4'd7, 8'h07);
    repeat (10) @(negedge clk);
    checkScan("d7", 7'b1111000, SEG_D1_OF_7);

    for (int n = 0; n < 20 && sbq.size() != 0; n++) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
